// File: rtl/sensor_spi_sched.sv
// Arbitrates the CMV300 SPI register engine between the host command port and a periodic
// status poller, times each transaction and returns read data. Poller built only with SENSOR_SPI_SCHED_POLL_EN.
module sensor_spi_sched #(
   parameter int unsigned XFER_CYCLES = 24,
   parameter logic [15:0] POLL_PERIOD = 16'd1000
) (
   input  logic       clk0,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rd,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_data,
   input  logic       poll_en,
   input  logic [6:0] poll_addr,
   output logic       rsp_valid,
   output logic       rsp_rd,
   output logic       rsp_poll,
   output logic [6:0] rsp_addr,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       spi_reset,
   output logic       spi_rd_en,
   output logic       spi_wr_en,
   output logic [6:0] spi_addr,
   output logic [7:0] spi_wr_data,
   input  logic [7:0] spi_reg_data
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [7:0] XFER_LOAD = 8'(XFER_CYCLES - 1);

   logic [1:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       spi_reset_q;
   logic       spi_rd_en_q, spi_rd_en_d;
   logic       spi_wr_en_q, spi_wr_en_d;
   logic [6:0] spi_addr_q, spi_addr_d;
   logic [7:0] spi_wr_data_q, spi_wr_data_d;
   logic       txn_rd_q, txn_rd_d;
   logic       txn_poll_q, txn_poll_d;
   logic       last_grant_q, last_grant_d;   // 1 = poller was granted last
   logic       rsp_valid_q, rsp_valid_d;
   logic       rsp_rd_q, rsp_rd_d;
   logic       rsp_poll_q, rsp_poll_d;
   logic [6:0] rsp_addr_q, rsp_addr_d;
   logic [7:0] rsp_data_q, rsp_data_d;

   logic idle;
   logic poll_req;
   logic grant_poll;
   logic grant_host;

   // Arbitration is only live once the engine has left reset.
   assign idle       = (state_q == ST_IDLE) && !spi_reset_q && reset;
   assign grant_poll = idle && poll_req && (!cmd_valid || !last_grant_q);
   assign grant_host = idle && cmd_valid && !grant_poll;
   assign cmd_ready  = idle && !grant_poll;

`ifdef SENSOR_SPI_SCHED_POLL_EN
   logic [15:0] poll_timer_q, poll_timer_d;
   logic        poll_pending_q, poll_pending_d;
   logic        poll_wrap;

   assign poll_wrap = (poll_timer_q == POLL_PERIOD - 16'd1);
   assign poll_req  = poll_pending_q;

   always_comb begin
      poll_timer_d   = 16'd0;
      poll_pending_d = 1'b0;
      if (poll_en) begin
         poll_timer_d = poll_wrap ? 16'd0 : poll_timer_q + 16'd1;
         // A grant consumes the request; an expiry landing on a pending request is dropped.
         if (grant_poll)
            poll_pending_d = 1'b0;
         else
            poll_pending_d = poll_pending_q | poll_wrap;
      end
   end

   always_ff @(posedge clk0) begin
      if (!reset) begin
         poll_timer_q   <= 16'd0;
         poll_pending_q <= 1'b0;
      end else begin
         poll_timer_q   <= poll_timer_d;
         poll_pending_q <= poll_pending_d;
      end
   end
`else
   logic unused_poll;
   assign poll_req    = 1'b0;
   assign unused_poll = ^{poll_en, POLL_PERIOD};
`endif

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      spi_rd_en_d   = 1'b0;
      spi_wr_en_d   = 1'b0;
      spi_addr_d    = spi_addr_q;
      spi_wr_data_d = spi_wr_data_q;
      txn_rd_d      = txn_rd_q;
      txn_poll_d    = txn_poll_q;
      last_grant_d  = last_grant_q;
      rsp_valid_d   = 1'b0;
      rsp_rd_d      = rsp_rd_q;
      rsp_poll_d    = rsp_poll_q;
      rsp_addr_d    = rsp_addr_q;
      rsp_data_d    = rsp_data_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_host) begin
               spi_addr_d    = cmd_addr;
               spi_wr_data_d = cmd_rd ? 8'h00 : cmd_data;
               txn_rd_d      = cmd_rd;
               txn_poll_d    = 1'b0;
               last_grant_d  = 1'b0;
               spi_rd_en_d   = cmd_rd;
               spi_wr_en_d   = !cmd_rd;
               state_d       = ST_ISSUE;
            end else if (grant_poll) begin
               spi_addr_d    = poll_addr;
               spi_wr_data_d = 8'h00;
               txn_rd_d      = 1'b1;
               txn_poll_d    = 1'b1;
               last_grant_d  = 1'b1;
               spi_rd_en_d   = 1'b1;
               state_d       = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = XFER_LOAD;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == 8'd0) begin
               rsp_valid_d = 1'b1;
               rsp_rd_d    = txn_rd_q;
               rsp_poll_d  = txn_poll_q;
               rsp_addr_d  = spi_addr_q;
               rsp_data_d  = txn_rd_q ? spi_reg_data : 8'h00;
               state_d     = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk0) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 8'd0;
         spi_reset_q   <= 1'b1;
         spi_rd_en_q   <= 1'b0;
         spi_wr_en_q   <= 1'b0;
         spi_addr_q    <= 7'd0;
         spi_wr_data_q <= 8'd0;
         txn_rd_q      <= 1'b0;
         txn_poll_q    <= 1'b0;
         last_grant_q  <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_rd_q      <= 1'b0;
         rsp_poll_q    <= 1'b0;
         rsp_addr_q    <= 7'd0;
         rsp_data_q    <= 8'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         spi_reset_q   <= 1'b0;
         spi_rd_en_q   <= spi_rd_en_d;
         spi_wr_en_q   <= spi_wr_en_d;
         spi_addr_q    <= spi_addr_d;
         spi_wr_data_q <= spi_wr_data_d;
         txn_rd_q      <= txn_rd_d;
         txn_poll_q    <= txn_poll_d;
         last_grant_q  <= last_grant_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rd_q      <= rsp_rd_d;
         rsp_poll_q    <= rsp_poll_d;
         rsp_addr_q    <= rsp_addr_d;
         rsp_data_q    <= rsp_data_d;
      end
   end

   assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign spi_reset   = spi_reset_q;
   assign spi_rd_en   = spi_rd_en_q;
   assign spi_wr_en   = spi_wr_en_q;
   assign spi_addr    = spi_addr_q;
   assign spi_wr_data = spi_wr_data_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rd      = rsp_rd_q;
   assign rsp_poll    = rsp_poll_q;
   assign rsp_addr    = rsp_addr_q;
   assign rsp_data    = rsp_data_q;

endmodule
